// File: rtl/fpu_muldiv_iter_pkg.sv
// Shared types and constants for the iterative single-precision multiply/divide unit.
package fpu_muldiv_iter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_UNPACK,
        MD_ITER,
        MD_NORM,
        MD_DONE
    } md_state_t;

    typedef enum logic [1:0] {
        CL_ZERO,
        CL_NORM,
        CL_INF,
        CL_NAN
    } fp_class_t;

    localparam int unsigned EXP_BIAS     = 127;
    localparam int unsigned ITER_CNT     = 26;
    localparam int unsigned MANT_W       = 24;
    localparam int unsigned FLAG_W       = 5;
    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF      = 32'h7F80_0000;

    // Denormals classify as zero (flush-to-zero on input).
    function automatic fp_class_t classify(input logic [7:0] e, input logic [22:0] f);
        if (e == 8'd0) begin
            return CL_ZERO;
        end else if (e == 8'hFF) begin
            return (f == 23'd0) ? CL_INF : CL_NAN;
        end
        return CL_NORM;
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Normalise by one bit, round to nearest-even, handle overflow/FTZ underflow and pack.
// Flag outputs exist only when FPU_FLAGS_EN is defined.
module fpu_round_pack
    import fpu_muldiv_iter_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [26:0]       sig,
    input  logic              sticky,
    output logic [31:0]       result
`ifdef FPU_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
`endif
);

    logic [23:0]       mant;
    logic              g, r, s, inc, ovf, unf;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_n, exp_r;
    logic [22:0]       frac;

    // sig has its leading one at bit 26 (value in [2,4)) or bit 25 (value in [1,2)).
    always_comb begin
        mant   = sig[25:2];
        g      = sig[1];
        r      = sig[0];
        s      = sticky;
        exp_n  = exp_in;
        if (sig[26]) begin
            mant  = sig[26:3];
            g     = sig[2];
            r     = sig[1];
            s     = sig[0] | sticky;
            exp_n = exp_in + 10'sd1;
        end
        inc    = g & (r | s | mant[0]);
        mant_r = {1'b0, mant} + 25'(inc);
        exp_r  = exp_n;
        frac   = mant_r[22:0];
        if (mant_r[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end
        ovf = (exp_r >= 10'sd255);
        unf = (exp_r <= 10'sd0);
        if (ovf) begin
            result = POS_INF | {sign, 31'd0};
        end else if (unf) begin
            result = {sign, 31'd0};
        end else begin
            result = {sign, exp_r[7:0], frac};
        end
    end

`ifdef FPU_FLAGS_EN
    assign overflow  = ovf;
    assign underflow = unf;
    assign inexact   = g | r | s | ovf | unf;
`endif

endmodule

// File: rtl/fpu_muldiv_iter.sv
// Iterative IEEE-754 single-precision MUL/DIV unit: shift-add multiply, restoring divide.
// Optional exception flags port enabled by defining FPU_FLAGS_EN.
module fpu_muldiv_iter
    import fpu_muldiv_iter_pkg::*;
#(
    parameter int unsigned EXTRA_LAT = 0,
    parameter logic [31:0] QNAN      = QNAN_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        fpuOp,
    input  logic [31:0]       opA,
    input  logic [31:0]       opB,
    output logic              busy,
    output logic              done,
    output logic [31:0]       fpuOut
`ifdef FPU_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] flags
`endif
);

    localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);

    md_state_t         state, state_next;
    logic [4:0]        cnt, cnt_next;
    logic              accept, is_div;
    logic [31:0]       a_r, b_r;
    fp_class_t         cls_a, cls_b;
    logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic              sign_c, invalid_c, special_c;
    logic [31:0]       spec_res_c;
    logic signed [9:0] ea_c, eb_c, exp_c;
    logic              sign_r, special_r;
    logic signed [9:0] exp_r;
    logic [23:0]       ma_r, mb_r;
    logic [31:0]       spec_res_r;
    logic [47:0]       prod;
    logic [24:0]       prod_sum;
    logic [25:0]       quo, rem;
    logic [24:0]       rem_diff;
    logic              rem_ge;
    logic [31:0]       rp_result;

    assign accept = start & ~busy & fpuOp[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next != MD_IDLE);
            done  <= (state_next == MD_DONE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 5'd1;
        case (state)
            MD_IDLE: begin
                cnt_next = '0;
                if (accept) state_next = MD_UNPACK;
            end
            MD_UNPACK: begin
                cnt_next   = '0;
                state_next = MD_ITER;
            end
            MD_ITER: begin
                if (cnt == 5'(ITER_CNT - 1)) begin
                    cnt_next   = '0;
                    state_next = MD_NORM;
                end
            end
            MD_NORM: begin
                if (cnt == 5'(EXTRA_LAT)) begin
                    cnt_next   = '0;
                    state_next = MD_DONE;
                end
            end
            MD_DONE: begin
                cnt_next   = '0;
                state_next = MD_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = MD_IDLE;
            end
        endcase
    end

    // Operand classification and special-case resolution.
    assign cls_a     = classify(a_r[30:23], a_r[22:0]);
    assign cls_b     = classify(b_r[30:23], b_r[22:0]);
    assign zero_a    = (cls_a == CL_ZERO);
    assign zero_b    = (cls_b == CL_ZERO);
    assign inf_a     = (cls_a == CL_INF);
    assign inf_b     = (cls_b == CL_INF);
    assign nan_a     = (cls_a == CL_NAN);
    assign nan_b     = (cls_b == CL_NAN);
    assign sign_c    = a_r[31] ^ b_r[31];
    assign invalid_c = nan_a | nan_b |
                       (is_div ? ((zero_a & zero_b) | (inf_a & inf_b))
                               : ((inf_a & zero_b) | (zero_a & inf_b)));
    assign ea_c      = signed'({2'b00, a_r[30:23]});
    assign eb_c      = signed'({2'b00, b_r[30:23]});
    assign exp_c     = is_div ? (ea_c - eb_c + BIAS_S) : (ea_c + eb_c - BIAS_S);

    always_comb begin
        special_c  = 1'b1;
        spec_res_c = {sign_c, 31'd0};
        if (invalid_c) begin
            spec_res_c = QNAN;
        end else if (inf_a || (!is_div && inf_b) || (is_div && zero_b)) begin
            spec_res_c = POS_INF | {sign_c, 31'd0};
        end else if (!(zero_a || zero_b || inf_b)) begin
            special_c = 1'b0;
        end
    end

    assign prod_sum = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, ma_r} : 25'd0);
    assign rem_ge   = (rem >= {2'b00, mb_r});
    assign rem_diff = 25'(rem - {2'b00, mb_r});

    always_ff @(posedge clk) begin
        if (accept) begin
            a_r    <= opA;
            b_r    <= opB;
            is_div <= (fpuOp == OP_DIV);
        end
        if (state == MD_UNPACK) begin
            sign_r     <= sign_c;
            exp_r      <= exp_c;
            ma_r       <= {1'b1, a_r[22:0]};
            mb_r       <= {1'b1, b_r[22:0]};
            special_r  <= special_c;
            spec_res_r <= spec_res_c;
            prod       <= {24'd0, 1'b1, b_r[22:0]};
            rem        <= {3'b001, a_r[22:0]};
            quo        <= '0;
        end
        // Multiply uses the first 24 steps; divide uses all 26.
        if (state == MD_ITER) begin
            if (cnt < 5'(MANT_W)) prod <= {prod_sum, prod[23:1]};
            quo <= {quo[24:0], rem_ge};
            rem <= {(rem_ge ? rem_diff : rem[24:0]), 1'b0};
        end
    end

`ifdef FPU_FLAGS_EN
    logic divzero_c, invalid_r, divzero_r;
    logic rp_ovf, rp_unf, rp_inx;
    assign divzero_c = is_div & (cls_a == CL_NORM) & zero_b;
    always_ff @(posedge clk) begin
        if (state == MD_UNPACK) begin
            invalid_r <= invalid_c;
            divzero_r <= divzero_c;
        end
    end
`endif

    // Divide quotient has weight 2^-25; shift it up one bit and compensate in the exponent.
    fpu_round_pack u_round_pack (
        .sign      (sign_r),
        .exp_in    (is_div ? (exp_r - 10'sd1) : exp_r),
        .sig       (is_div ? {quo, 1'b0} : prod[47:21]),
        .sticky    (is_div ? (rem != 26'd0) : (|prod[20:0])),
        .result    (rp_result)
`ifdef FPU_FLAGS_EN
        ,
        .overflow  (rp_ovf),
        .underflow (rp_unf),
        .inexact   (rp_inx)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fpuOut <= '0;
`ifdef FPU_FLAGS_EN
            flags  <= '0;
`endif
        end else if (state == MD_NORM && state_next == MD_DONE) begin
            fpuOut <= special_r ? spec_res_r : rp_result;
`ifdef FPU_FLAGS_EN
            flags  <= special_r ? {invalid_r, divzero_r, 3'b000}
                                : {2'b00, rp_ovf, rp_unf, rp_inx};
`endif
        end
    end

endmodule

// File: tb/tb_fpu_muldiv_iter.sv
// Bench for fpu_muldiv_iter: directed vector table, handshake corner sequences and
// random operations against an exact-arithmetic reference model.
module tb_fpu_muldiv_iter;

    localparam int          EXTRA = 0;
    localparam int          LAT   = 29 + EXTRA;
    localparam logic [1:0]  T_ADD = 2'b00;
    localparam logic [1:0]  T_MUL = 2'b10;
    localparam logic [1:0]  T_DIV = 2'b11;
    localparam logic [31:0] T_QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  fpuOp = 2'b00;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        busy, done;
    logic [31:0] fpuOut;
    logic [4:0]  flags_s;

    int checks = 0;
    int errors = 0;

    fpu_muldiv_iter #(.EXTRA_LAT(EXTRA)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .fpuOp  (fpuOp),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .fpuOut (fpuOut)
`ifdef FPU_FLAGS_EN
        ,
        .flags  (flags_s)
`endif
    );

`ifndef FPU_FLAGS_EN
    assign flags_s = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Reference: value = m * 2^e2 (plus sticky below m), rounded RNE with FTZ.
    function automatic logic [36:0] round_model(input logic s, input longint unsigned m,
                                                input int e2, input bit sticky);
        int k = 0;
        int sh, be;
        longint unsigned mant, remv, half;
        bit up, inx;
        for (int i = 63; i >= 0; i--) begin
            if (m[i]) begin k = i; break; end
        end
        sh   = k - 23;
        mant = m >> sh;
        remv = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (remv > half) || (remv == half && (sticky || mant[0]));
        inx  = (remv != 0) || sticky;
        mant = mant + (up ? 64'd1 : 64'd0);
        be   = k + e2 + 127;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            be++;
        end
        if (be >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        if (be <= 0) return {5'b00011, s, 31'd0};
        return {4'b0000, inx, s, 8'(be), mant[22:0]};
    endfunction

    function automatic logic [36:0] ref_model(input bit is_div, input logic [31:0] a,
                                              input logic [31:0] b);
        int ea, eb;
        bit za, zb, ia, ib, na, nb;
        logic s;
        longint unsigned ma, mb, num;
        logic [31:0] inf, zero;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        inf  = {s, 8'hFF, 23'd0};
        zero = {s, 31'd0};
        ma = {40'd1, a[22:0]};
        mb = {40'd1, b[22:0]};
        if (na || nb) return {5'b10000, T_QNAN};
        if (!is_div) begin
            if ((ia && zb) || (za && ib)) return {5'b10000, T_QNAN};
            if (ia || ib) return {5'b00000, inf};
            if (za || zb) return {5'b00000, zero};
            return round_model(s, ma * mb, ea + eb - 300, 1'b0);
        end
        if ((za && zb) || (ia && ib)) return {5'b10000, T_QNAN};
        if (ia) return {5'b00000, inf};
        if (zb) return {5'b01000, inf};
        if (za || ib) return {5'b00000, zero};
        num = ma << 40;
        return round_model(s, num / mb, ea - eb - 40, (num % mb) != 0);
    endfunction

    // One operation; optional re-start poke or reset at a given busy cycle (-5 disables).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_k, input int rst_k,
                          output logic [31:0] res, output logic [4:0] fl,
                          output int nbusy, output int done_k, output int ndone,
                          output logic busy_rst, output logic [31:0] out_rst);
        nbusy = 0; done_k = 0; ndone = 0;
        res = 32'hDEAD_BEEF; fl = 5'h1F; busy_rst = 1'b1; out_rst = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b1; fpuOp = op; opA = a; opB = b;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; opA = $urandom; opB = $urandom;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++; done_k = k; res = fpuOut; fl = flags_s;
            end
            if (k == rst_k + 1) begin
                busy_rst = busy; out_rst = fpuOut; reset = 1'b0;
            end
            if (k == poke_k) begin
                start = 1'b1; fpuOp = T_DIV; opA = 32'h3F80_0000; opB = 32'h0;
            end
            if (k == poke_k + 1) start = 1'b0;
            if (k == rst_k) reset = 1'b1;
            if (!busy) break;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:0] = {8'hFF, v[22:1], 1'b1};
            3: v[30:23] = 8'd0;
            4: v[30:23] = $urandom_range(0, 1) ? 8'(250 + $urandom_range(0, 4)) : 8'(1 + $urandom_range(0, 4));
            default: v[30:23] = 8'(64 + $urandom_range(0, 126));
        endcase
        return v;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] res, out_rst, prev;
        logic [4:0]  fl;
        logic        busy_rst;
        logic [36:0] exp_m;
        int nbusy, done_k, ndone, cnt_busy, cnt_done;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{T_MUL, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 5'b00000};
        vecs[1]  = '{T_DIV, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00001};
        vecs[2]  = '{T_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000};
        vecs[3]  = '{T_DIV, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000};
        vecs[4]  = '{T_DIV, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000};
        vecs[5]  = '{T_MUL, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000};
        vecs[6]  = '{T_MUL, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 5'b00101};
        vecs[7]  = '{T_MUL, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 5'b00011};
        vecs[8]  = '{T_MUL, 32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 5'b00000};
        vecs[9]  = '{T_DIV, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 5'b00000};
        vecs[10] = '{T_MUL, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000};
        vecs[11] = '{T_DIV, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 5'b00000};
        vecs[12] = '{T_MUL, 32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 5'b00000};
        vecs[13] = '{T_DIV, 32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", fpuOut, 32'd0);
        check("reset_flags", 32'(flags_s), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -5, -5, res, fl, nbusy, done_k, ndone,
                   busy_rst, out_rst);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'(LAT));
            check($sformatf("vec%0d_done_cycle", i), 32'(done_k), 32'(LAT));
`ifdef FPU_FLAGS_EN
            check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
`endif
        end

        // start while busy must be ignored
        run_op(T_MUL, 32'h4040_0000, 32'h4000_0000, 5, -5, res, fl, nbusy, done_k, ndone,
               busy_rst, out_rst);
        check("poke_result", res, 32'h40C0_0000);
        check("poke_busy_cycles", 32'(nbusy), 32'(LAT));
        check("poke_done_count", 32'(ndone), 32'd1);

        // ADD request is not accepted; output holds
        prev = fpuOut;
        @(negedge clk);
        start = 1'b1; fpuOp = T_ADD; opA = 32'h3F80_0000; opB = 32'h3F80_0000;
        @(negedge clk);
        start = 1'b0;
        cnt_busy = 0; cnt_done = 0;
        for (int k = 0; k < 35; k++) begin
            if (busy) cnt_busy++;
            if (done) cnt_done++;
            @(negedge clk);
        end
        check("add_busy", 32'(cnt_busy), 32'd0);
        check("add_done", 32'(cnt_done), 32'd0);
        check("add_out_held", fpuOut, prev);

        // reset in the middle of a divide
        run_op(T_DIV, 32'h4040_0000, 32'h3F80_0000, -5, 10, res, fl, nbusy, done_k, ndone,
               busy_rst, out_rst);
        check("midrst_busy", 32'(busy_rst), 32'd0);
        check("midrst_out", out_rst, 32'd0);
        check("midrst_done", 32'(ndone), 32'd0);
        cnt_done = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("midrst_no_late_done", 32'(cnt_done), 32'd0);
        run_op(T_MUL, 32'h4040_0000, 32'h4000_0000, -5, -5, res, fl, nbusy, done_k, ndone,
               busy_rst, out_rst);
        check("after_rst_result", res, 32'h40C0_0000);
        check("after_rst_done_cycle", 32'(done_k), 32'(LAT));

        for (int i = 0; i < 150; i++) begin
            rop = $urandom_range(0, 1) ? T_DIV : T_MUL;
            ra = rand_operand();
            rb = rand_operand();
            exp_m = ref_model(rop == T_DIV, ra, rb);
            run_op(rop, ra, rb, -5, -5, res, fl, nbusy, done_k, ndone, busy_rst, out_rst);
            check($sformatf("rand%0d_%h_%h_%h", i, rop, ra, rb), res, exp_m[31:0]);
`ifdef FPU_FLAGS_EN
            check($sformatf("rand%0d_flags", i), 32'(fl), 32'(exp_m[36:32]));
`endif
            if (i % 25 == 0) check($sformatf("rand%0d_done_cycle", i), 32'(done_k), 32'(LAT));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
